// File: rtl/symbol_histogram_pkg.sv
// Shared sizing helpers and legal parameter bounds for the symbol histogram.
package symbol_histogram_pkg;

  localparam int SYM_BITS_MAX = 4;
  localparam int CNT_W_MAX    = 16;

  function automatic int nbins(input int sym_bits);
    return 1 << sym_bits;
  endfunction

  // LSB position of bin k inside a packed NBINS*CNT_W vector.
  function automatic int bin_lsb(input int k, input int cnt_w);
    return k * cnt_w;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that holds at all-ones and flags increments lost to saturation.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         sat_hit
);

  logic [W-1:0] q_q, q_d;
  logic         full;

  always_comb begin
    full    = &q_q;
    sat_hit = inc & ~clr & full;
    q_d     = q_q;
    // clr discards the old count; a coincident inc becomes the first event of the new run
    if (clr)              q_d = W'(inc);
    else if (inc && !full) q_d = q_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/symbol_histogram.sv
// Frame-gated serial symbol histogram: deserialises MSB-first symbols, counts them
// per value in saturating bins, and publishes a snapshot when the frame closes.
module symbol_histogram
  import symbol_histogram_pkg::*;
#(
  parameter int SYM_BITS = 2,
  parameter int CNT_W    = 8,
  parameter int TOT_W    = CNT_W + SYM_BITS
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               data,
  input  logic                               frame,
  output logic [nbins(SYM_BITS)*CNT_W-1:0]   cnt,
  output logic [nbins(SYM_BITS)*CNT_W-1:0]   hist,
  output logic                               hist_valid,
  output logic [TOT_W-1:0]                   total,
  output logic                               sat,
  output logic                               partial,
  output logic [1:0]                         partial_cnt
);

  localparam int NBINS = nbins(SYM_BITS);
  localparam int SHW   = (SYM_BITS > 1) ? SYM_BITS - 1 : 1;

  if (SYM_BITS < 1 || SYM_BITS > SYM_BITS_MAX) begin : g_bad_sym
    $error("symbol_histogram: SYM_BITS out of range");
  end
  if (CNT_W < 2 || CNT_W > CNT_W_MAX) begin : g_bad_cnt
    $error("symbol_histogram: CNT_W out of range");
  end

  logic                   frame_prev_q, frame_prev_d;
  logic [1:0]             bit_idx_q, bit_idx_d;
  logic [SHW-1:0]         shreg_q, shreg_d;
  logic                   sat_live_q, sat_live_d;
  logic [NBINS*CNT_W-1:0] hist_q, hist_d;
  logic [TOT_W-1:0]       total_q, total_d;
  logic                   sat_q, sat_d;
  logic                   partial_q, partial_d;
  logic [1:0]             pcnt_q, pcnt_d;
  logic                   hv_q, hv_d;

  logic                   start, run, fin, last_bit, complete;
  logic [SHW:0]           sym_full;
  logic [SYM_BITS-1:0]    sym;
  logic [NBINS-1:0]       bin_inc, bin_hit;
  logic [NBINS*CNT_W-1:0] cnt_w;
  logic [TOT_W-1:0]       tot_live;
  logic                   tot_hit;

  always_comb begin
    start    = frame & ~frame_prev_q;
    run      = frame & frame_prev_q;
    fin      = ~frame & frame_prev_q;
    last_bit = (bit_idx_q == 2'(SYM_BITS - 1));
    // with one-bit symbols the start bit already completes a symbol
    complete = (run & last_bit) | (start & (SYM_BITS == 1));
    sym_full = {shreg_q, data};
    sym      = sym_full[SYM_BITS-1:0];
    for (int k = 0; k < NBINS; k++) bin_inc[k] = complete && (sym == SYM_BITS'(k));
  end

  for (genvar k = 0; k < NBINS; k++) begin : g_bin
    sat_counter #(.W(CNT_W)) u_bin (
      .clk     (clk),
      .rst     (rst),
      .clr     (start),
      .inc     (bin_inc[k]),
      .q       (cnt_w[bin_lsb(k, CNT_W) +: CNT_W]),
      .sat_hit (bin_hit[k])
    );
  end

  sat_counter #(.W(TOT_W)) u_total (
    .clk     (clk),
    .rst     (rst),
    .clr     (start),
    .inc     (complete),
    .q       (tot_live),
    .sat_hit (tot_hit)
  );

  always_comb begin
    frame_prev_d = frame_prev_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    sat_live_d   = sat_live_q | (|bin_hit) | tot_hit;
    hist_d       = hist_q;
    total_d      = total_q;
    sat_d        = sat_q;
    partial_d    = partial_q;
    pcnt_d       = pcnt_q;
    hv_d         = 1'b0;
    if (start) begin
      frame_prev_d = 1'b1;
      sat_live_d   = 1'b0;
      if (SYM_BITS > 1) begin
        bit_idx_d = 2'd1;
        shreg_d   = SHW'(data);
      end
    end else if (run) begin
      if (last_bit) begin
        bit_idx_d = 2'd0;
      end else begin
        bit_idx_d = bit_idx_q + 2'd1;
        shreg_d   = SHW'({shreg_q, data});
      end
    end else if (fin) begin
      frame_prev_d = 1'b0;
      hist_d       = cnt_w;
      total_d      = tot_live;
      sat_d        = sat_live_q;
      partial_d    = (bit_idx_q != 2'd0);
      pcnt_d       = bit_idx_q;
      hv_d         = 1'b1;
      bit_idx_d    = 2'd0;
      shreg_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_prev_q <= 1'b0;
      bit_idx_q    <= 2'd0;
      shreg_q      <= '0;
      sat_live_q   <= 1'b0;
      hist_q       <= '0;
      total_q      <= '0;
      sat_q        <= 1'b0;
      partial_q    <= 1'b0;
      pcnt_q       <= 2'd0;
      hv_q         <= 1'b0;
    end else begin
      frame_prev_q <= frame_prev_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      sat_live_q   <= sat_live_d;
      hist_q       <= hist_d;
      total_q      <= total_d;
      sat_q        <= sat_d;
      partial_q    <= partial_d;
      pcnt_q       <= pcnt_d;
      hv_q         <= hv_d;
    end
  end

  assign cnt         = cnt_w;
  assign hist        = hist_q;
  assign hist_valid  = hv_q;
  assign total       = total_q;
  assign sat         = sat_q;
  assign partial     = partial_q;
  assign partial_cnt = pcnt_q;

endmodule

// File: doc/symbol_histogram.md
# symbol_histogram

Parametrised frame-gated symbol histogram. Deserialises a 1-bit `data` stream into MSB-first symbols of `SYM_BITS` bits while `frame` is high and counts occurrences of each of the 2^SYM_BITS symbol values in saturating counters. At frame end it publishes a latched snapshot with a one-cycle valid strobe, a total symbol count and partial-symbol status. It sits beside the serial link capture logic as the statistics source for link bit-pattern diagnostics, and supersedes the fixed 2-bit/8-bit pair counter.

## Interface
- `SYM_BITS`, default 2: bits per symbol, legal range 1..4; NBINS = 2^SYM_BITS.
- `CNT_W`, default 8: width of each bin counter, legal range 2..16.
- `TOT_W`, default CNT_W+SYM_BITS: width of the total-symbol counter.
- `clk` in 1: sole clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `data` in 1: serial data, sampled every cycle while `frame` is high.
- `frame` in 1: frame enable; a rising edge starts a frame and a falling edge ends it.
- `cnt` out NBINS*CNT_W: live bin counts; bin k occupies bits [k*CNT_W +: CNT_W].
- `hist` out NBINS*CNT_W: bin counts latched at frame end, same packing as `cnt`.
- `hist_valid` out 1: one-cycle pulse when `hist` and the status outputs update.
- `total` out TOT_W: number of symbols completed in the last finished frame, saturating.
- `sat` out 1: set if any bin or `total` saturated during the last finished frame.
- `partial` out 1: the last finished frame ended with an incomplete symbol.
- `partial_cnt` out 2: number of bits held in the incomplete symbol (0 when `partial`=0).

## Operation
- Internal state:
  - `frame_prev`: previous-cycle `frame`.
  - `bit_idx`: range 0..SYM_BITS-1.
  - `shreg`: SYM_BITS-1 bits.
  - Live total counter and live saturation flag.
- Idle (`frame`=0, `frame_prev`=0): all state holds.
- Start cycle (`frame`=1, `frame_prev`=0):
  - Clear all live bins, the live total and the live sat flag.
  - Set `frame_prev`=1.
  - First bit is captured as the symbol MSB: `shreg` gets `data` and `bit_idx` becomes 1.
  - If SYM_BITS=1, the start bit is itself a full symbol: bin[`data`]=1, total=1, `bit_idx` stays 0.
- Run cycle (`frame`=1, `frame_prev`=1):
  - If `bit_idx` < SYM_BITS-1: shift `data` into `shreg` (MSB-first) and increment `bit_idx`.
  - Otherwise the completed symbol is {`shreg`, `data`}:
    - Increment that bin and the live total.
    - Reset `bit_idx` to 0.
- End cycle (`frame`=0, `frame_prev`=1):
  - Clear `frame_prev`.
  - Copy live bins to `hist`, live total to `total` and live sat to `sat`.
  - `partial` = (`bit_idx`≠0); `partial_cnt` = `bit_idx`.
  - Pulse `hist_valid`.
  - Discard partial bits.
  - Live `cnt` keeps its values until the next start cycle.
- Saturation:
  - A counter at all-ones does not wrap; it holds its value.
  - An increment attempted on a saturated counter sets live sat.
  - Each bin and `total` saturate independently.
- Frame of one cycle (start then immediately end):
  - Snapshot is all bins 0, `total`=0, `partial`=1, `partial_cnt`=1.
  - Exception: with SYM_BITS=1, the single bin is 1, `total`=1 and `partial`=0.
- Reset (any cycle, including mid-frame):
  - All outputs, all live counters, `frame_prev`, `bit_idx` and `shreg` go to 0.
  - No `hist_valid` is issued.
  - If `frame` is still high after `rst` falls, the first such cycle is a start cycle.

## Timing
- Inputs are registered on the rising edge of `clk`; all outputs are registers with no combinational paths from input to output.
- A completed symbol shows up on `cnt` one cycle after its last bit is sampled.
- `hist`, `total`, `sat`, `partial`, `partial_cnt` and `hist_valid` update together one cycle after the first low-`frame` sample.
- `hist_valid` deasserts on the following cycle; the snapshot outputs hold until the next end cycle or reset.
- Back-to-back frames with a single low cycle between them are legal. The snapshot of frame N stays stable while frame N+1 runs.
- Throughput: one bit per cycle, with no stall.

## Structure
- Package `symbol_histogram_pkg` holds:
  - the function computing NBINS from SYM_BITS;
  - the bin-slice index helper;
  - the legal-range constants SYM_BITS_MAX=4 and CNT_W_MAX=16, used by elaboration-time checks.
- Sub-module `sat_counter`, parameter W, ports `clk`, `rst`, `clr`, `inc`, `q`, `sat_hit`:
  - instantiated NBINS times for the bins and once (W=TOT_W) for the total.
  - `clr` has priority over `inc`.
- The top level holds the frame edge detection, deserialiser, bin decode and snapshot registers.

## Test plan
- SYM_BITS=2, CNT_W=8; `frame` high for 8 cycles with `data` 0,0,0,1,1,0,1,1 -> one-cycle `hist_valid`; every bin =1; `total`=4; `partial`=0; `sat`=0.
- SYM_BITS=2; 5-bit frame 1,1,1,1,0 -> bin3=2, other bins 0; `total`=2; `partial`=1; `partial_cnt`=1.
- SYM_BITS=2, CNT_W=4; 40 bits of 1 -> bin3=15; `total`=20; `sat`=1; live `cnt` bin3 holds 15 after frame end.
- SYM_BITS=3; `data` 1,0,1 repeated 3 times, then `frame` low one cycle, then a 3-bit frame 0,0,0:
  - first snapshot: bin5=3;
  - live bins clear on the second frame's start cycle while `hist` still shows bin5=3;
  - second snapshot: bin0=1, bin5=0.
- `rst` pulsed mid-frame after 3 bits while `frame` stays high:
  - next cycle all outputs and counters are 0 and no `hist_valid` is issued;
  - the cycle after `rst` falls is a start cycle, and a later falling `frame` reports only the post-reset bits.
- SYM_BITS=1; one-cycle frame with `data`=1 -> bin1=1, bin0=0; `total`=1; `partial`=0.
